// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the audio codec configuration sequencer.
// The word table gives the codec's power-on register programming order.
package codec_cfg_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP  = 4'd0,
        ST_LOAD   = 4'd1,
        ST_REQ    = 4'd2,
        ST_WAIT   = 4'd3,
        ST_GAP    = 4'd4,
        ST_DONE   = 4'd5,
        ST_ABORT  = 4'd6,
        ST_REINIT = 4'd7,
        ST_ERR    = 4'd8
    } cfg_state_t;

    localparam int         NUM_WORDS      = 11;
    localparam logic [7:0] DEF_SLAVE_ADDR = 8'h34;

    // Each entry is {7-bit register address, 9-bit register data}.
    localparam logic [15:0] CFG_TABLE [NUM_WORDS] = '{
        {7'h0F, 9'h000},    // reset
        {7'h00, 9'h017},    // left line in
        {7'h01, 9'h017},    // right line in
        {7'h02, 9'h079},    // left headphone out
        {7'h03, 9'h079},    // right headphone out
        {7'h04, 9'h012},    // analog path
        {7'h05, 9'h000},    // digital path
        {7'h06, 9'h000},    // power down control
        {7'h07, 9'h001},    // digital interface format
        {7'h08, 9'h000},    // sampling control
        {7'h09, 9'h001}     // activate
    };

    // Table lookup that stays defined for the unused index codes 11..15.
    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        logic [15:0] w;
        w = 16'h0000;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx == 4'(i)) w = CFG_TABLE[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_tick.sv
// SCL base clock divider: a half-period counter that toggles CLOCK_500 at
// each wrap and marks the rising (ena) and falling (SDAT step) toggles.
module i2c_tick_gen
    import codec_cfg_pkg::*;
#(
    parameter int HALF_DIV = 79
) (
    input  logic CLOCK31_5,
    input  logic RESET,
    output logic CLOCK_500,
    output logic CLOCK_500_ena,
    output logic CLOCK_SDAT_ena
);

    localparam logic [15:0] WRAP_VAL = 16'(HALF_DIV - 1);

    logic [15:0] div_cnt;

    // Free-running half-period counter; one-cycle pulses on each toggle.
    always_ff @(posedge CLOCK31_5 or negedge RESET) begin
        if (!RESET) begin
            div_cnt        <= 16'd0;
            CLOCK_500      <= 1'b0;
            CLOCK_500_ena  <= 1'b0;
            CLOCK_SDAT_ena <= 1'b0;
        end else begin
            CLOCK_500_ena  <= 1'b0;
            CLOCK_SDAT_ena <= 1'b0;
            if (div_cnt == WRAP_VAL) begin
                div_cnt   <= 16'd0;
                CLOCK_500 <= ~CLOCK_500;
                if (CLOCK_500) CLOCK_SDAT_ena <= 1'b1;
                else           CLOCK_500_ena  <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Codec configuration sequencer: walks the register table, handing one
// 24-bit word at a time to the I2C engine and supervising each word.
//
// state     | meaning
// ----------+---------------------------------------------------------
// PWRUP     | wait PWRUP_TICKS SDAT ticks after reset release
// LOAD      | latch {SLAVE_ADDR, table[WORD_IDX]} onto I2C_DATA
// REQ       | request raised, timeout counter cleared
// WAIT      | wait for NEXT_WORD, abort on timeout
// GAP       | GAP_TICKS idle ticks, then next word or DONE
// DONE      | table complete (terminal)
// ABORT     | engine held in reset for 2 cycles after a timeout
// REINIT    | engine held in reset for 2 cycles, then restart at word 0
// ERR       | aborted (terminal)
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int          HALF_DIV      = 79,
    parameter logic [15:0] PWRUP_TICKS   = 16'd2000,
    parameter int          GAP_TICKS     = 4,
    parameter int          TIMEOUT_TICKS = 48,
    parameter logic [7:0]  SLAVE_ADDR    = DEF_SLAVE_ADDR
) (
    input  logic        CLOCK31_5,
    input  logic        RESET,
    input  logic        REINIT,
    input  logic        NEXT_WORD,
    output logic        CLOCK_500,
    output logic        CLOCK_500_ena,
    output logic        CLOCK_SDAT_ena,
    output logic        TRANSACTION_REQ,
    output logic [23:0] I2C_DATA,
    output logic        I2C_RST_N,
    output logic        CFG_BUSY,
    output logic        CFG_DONE,
    output logic        CFG_ERR,
    output logic [3:0]  WORD_IDX
);

    localparam logic [15:0] GAP_LIM  = 16'(GAP_TICKS);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_TICKS);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_WORDS - 1);

    cfg_state_t  state;
    logic [15:0] tick_cnt;

    i2c_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .CLOCK31_5      (CLOCK31_5),
        .RESET          (RESET),
        .CLOCK_500      (CLOCK_500),
        .CLOCK_500_ena  (CLOCK_500_ena),
        .CLOCK_SDAT_ena (CLOCK_SDAT_ena)
    );

    // Sequencer FSM with all handshake and status outputs registered.
    always_ff @(posedge CLOCK31_5 or negedge RESET) begin
        if (!RESET) begin
            state           <= ST_PWRUP;
            tick_cnt        <= 16'd0;
            WORD_IDX        <= 4'd0;
            TRANSACTION_REQ <= 1'b0;
            I2C_DATA        <= 24'h0;
            I2C_RST_N       <= 1'b0;
            CFG_BUSY        <= 1'b1;
            CFG_DONE        <= 1'b0;
            CFG_ERR         <= 1'b0;
        end else if (REINIT && state != ST_ABORT && state != ST_REINIT) begin
            // Restart request; a REINIT while the engine is already being
            // reset is absorbed by the branch condition above.
            state           <= ST_REINIT;
            tick_cnt        <= 16'd0;
            WORD_IDX        <= 4'd0;
            TRANSACTION_REQ <= 1'b0;
            I2C_RST_N       <= 1'b0;
            CFG_BUSY        <= 1'b1;
            CFG_DONE        <= 1'b0;
            CFG_ERR         <= 1'b0;
        end else begin
            case (state)
                ST_PWRUP: begin
                    I2C_RST_N <= 1'b1;
                    if (tick_cnt == PWRUP_TICKS) begin
                        tick_cnt <= 16'd0;
                        state    <= ST_LOAD;
                    end else if (CLOCK_SDAT_ena) begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                ST_LOAD: begin
                    I2C_DATA        <= {SLAVE_ADDR, cfg_word(WORD_IDX)};
                    TRANSACTION_REQ <= 1'b1;
                    state           <= ST_REQ;
                end
                ST_REQ: begin
                    tick_cnt <= 16'd0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // NEXT_WORD is tested first so it wins over a same-cycle timeout.
                    if (NEXT_WORD) begin
                        TRANSACTION_REQ <= 1'b0;
                        tick_cnt        <= 16'd0;
                        state           <= ST_GAP;
                    end else if (tick_cnt == TO_LIM) begin
                        TRANSACTION_REQ <= 1'b0;
                        I2C_RST_N       <= 1'b0;
                        tick_cnt        <= 16'd0;
                        state           <= ST_ABORT;
                    end else if (CLOCK_SDAT_ena) begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (tick_cnt == GAP_LIM) begin
                        tick_cnt <= 16'd0;
                        if (WORD_IDX >= LAST_IDX) begin
                            CFG_BUSY <= 1'b0;
                            CFG_DONE <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            WORD_IDX <= WORD_IDX + 4'd1;
                            state    <= ST_LOAD;
                        end
                    end else if (CLOCK_SDAT_ena) begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                ST_ABORT: begin
                    if (tick_cnt == 16'd1) begin
                        tick_cnt  <= 16'd0;
                        I2C_RST_N <= 1'b1;
                        CFG_BUSY  <= 1'b0;
                        CFG_ERR   <= 1'b1;
                        state     <= ST_ERR;
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                ST_REINIT: begin
                    if (tick_cnt == 16'd1) begin
                        tick_cnt  <= 16'd0;
                        I2C_RST_N <= 1'b1;
                        state     <= ST_LOAD;
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state <= state;
                end
                default: begin
                    state <= ST_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: doc/codec_cfg_sequencer.md
CODEC_CFG_SEQUENCER -- requirements
Module: codec_cfg_sequencer

Interface
REQ-001 Parameter HALF_DIV, 79, CLOCK31_5 cycles per half period of CLOCK_500 (79 gives about 199 kHz SCL).
REQ-002 Parameter PWRUP_TICKS, 16'd2000, number of CLOCK_SDAT_ena ticks after reset release before the first word.
REQ-003 Parameter GAP_TICKS, 4, number of idle SDAT ticks between words with TRANSACTION_REQ low.
REQ-004 Parameter TIMEOUT_TICKS, 48, number of SDAT ticks allowed from request to NEXT_WORD before abort.
REQ-005 Parameter SLAVE_ADDR, 8'h34, codec write address forming I2C_DATA[23:16].
REQ-006 Port CLOCK31_5, in, 1, system clock; all logic is rising-edge.
REQ-007 Port RESET, in, 1, asynchronous active-low reset.
REQ-008 Port REINIT, in, 1, single-cycle pulse that restarts the whole configuration table.
REQ-009 Port NEXT_WORD, in, 1, one-cycle pulse from the I2C engine marking the end of a word.
REQ-010 Port CLOCK_500, out, 1, SCL base square wave to the engine.
REQ-011 Port CLOCK_500_ena, out, 1, one-cycle pulse on each 0->1 toggle of CLOCK_500.
REQ-012 Port CLOCK_SDAT_ena, out, 1, one-cycle pulse on each 1->0 toggle of CLOCK_500; this is the engine bit step.
REQ-013 Port TRANSACTION_REQ, out, 1, request to the engine to run a word.
REQ-014 Port I2C_DATA, out, 24, {SLAVE_ADDR, register word}.
REQ-015 Port I2C_RST_N, out, 1, active-low local reset to the engine, registered.
REQ-016 Ports CFG_BUSY, CFG_DONE, CFG_ERR, out, 1 each, status outputs.
REQ-017 Port WORD_IDX, out, 4, index of the current or last table entry.

Function
REQ-018 Tick divider: counter 0..HALF_DIV-1 free-runs from reset release; at wrap CLOCK_500 toggles and the matching ena pulse fires. Pulses never overlap and are exactly one cycle wide.
REQ-019 The table holds NUM_WORDS=11 entries of 16 bits, {7-bit reg addr, 9-bit data}, fixed in the package, ordered per the codec init order.
REQ-020 FSM states and transitions:
- PWRUP: wait PWRUP_TICKS, then LOAD.
- LOAD: one cycle; I2C_DATA <= {SLAVE_ADDR, table[WORD_IDX]}, then REQ.
- REQ: TRANSACTION_REQ=1, timeout count cleared, then WAIT.
- WAIT: on NEXT_WORD go to GAP; on timeout go to ABORT.
- GAP: GAP_TICKS, then LOAD with index+1, or DONE after the last index.
- DONE: terminal.
- ABORT: I2C_RST_N=0 for exactly 2 cycles, then ERR.
- ERR: terminal.
REQ-021 TRANSACTION_REQ is high only in REQ and WAIT, and drops in the same cycle NEXT_WORD is sampled high.
REQ-022 I2C_DATA is stable from LOAD until the cycle after NEXT_WORD; it never changes while TRANSACTION_REQ=1.
REQ-023 Timeout counter: increments on CLOCK_SDAT_ena in WAIT only; abort fires when it equals TIMEOUT_TICKS. No retry.
REQ-024 NEXT_WORD outside WAIT is ignored; no state or index change.
REQ-025 NEXT_WORD and the timeout in the same cycle: NEXT_WORD wins.
REQ-026 REINIT in any state: next cycle go to ABORT-style 2-cycle engine reset, WORD_IDX=0, CFG_ERR/CFG_DONE cleared, then LOAD (no power-up wait). REINIT during the engine-reset cycles is absorbed.
REQ-027 Status outputs, all registered:
- CFG_BUSY=1 in all states except DONE and ERR.
- CFG_DONE=1 only in DONE.
- CFG_ERR=1 only in ERR.
REQ-028 WORD_IDX is 4-bit, saturates at NUM_WORDS-1, and never wraps.

Reset
REQ-029 RESET low, asynchronously:
- State=PWRUP, all counters 0, WORD_IDX=0.
- CLOCK_500=0, both ena outputs=0, TRANSACTION_REQ=0.
- I2C_DATA=24'h0, I2C_RST_N=0.
- CFG_BUSY=1, CFG_DONE=0, CFG_ERR=0.
REQ-030 I2C_RST_N goes to 1 on the first clock after RESET release.
REQ-031 RESET asserted mid-word aborts with no further engine handshake; after release the sequence restarts from PWRUP.

Structure
REQ-032 Package codec_cfg_pkg holds:
- the FSM state enum;
- NUM_WORDS;
- the 16-bit word table constant;
- the default SLAVE_ADDR.
REQ-033 Sub-module i2c_tick_gen provides the divider and tick outputs (REQ-018); the FSM stays in codec_cfg_sequencer.

Verification
REQ-034 Reset release with HALF_DIV=4: CLOCK_500 period = 8 cycles; SDAT_ena pulses every 8 cycles, 4 cycles offset from CLOCK_500_ena.
REQ-035 PWRUP_TICKS=2, with an engine model answering NEXT_WORD 33 ticks after the request:
- 11 words issued;
- I2C_DATA[23:16]=8'h34 on each;
- WORD_IDX 0..10 in order;
- CFG_DONE=1, CFG_BUSY=0 at the end.
REQ-036 Engine model silent on word 3 with TIMEOUT_TICKS=48: abort at tick 48, I2C_RST_N low for 2 cycles, CFG_ERR=1, TRANSACTION_REQ=0, WORD_IDX=3.
REQ-037 REINIT pulsed during word 5: 2-cycle engine reset, WORD_IDX=0, then the full table completes with CFG_DONE=1.
REQ-038 Boundary pulses:
- Spurious NEXT_WORD during GAP: no index change.
- NEXT_WORD coincident with the timeout: proceeds to GAP, CFG_ERR=0.
REQ-039 RESET asserted mid-WAIT: all outputs take REQ-029 values immediately; normal completion follows release.
